// File: rtl/dpwm_gen_10b.sv
// dpwm_gen_10b: 10-bit digital PWM generator with a complementary output pair.
// Samples cant_corriente as the duty and applies it through a shadow register.
// The shadow is reloaded only at period boundaries, so a duty change never
// alters the period already in progress.
// Optional feature: define DPWM_DEADTIME_EN to delay every rising edge of
// pwm_out and pwm_n by DEADTIME clocks. Falling edges are not delayed, so the
// high-side and low-side drivers are never on together.
module dpwm_gen_10b #(
   parameter int WIDTH    = 10,
   parameter int PRESCALE = 1,
   parameter int DEADTIME = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] cant_corriente,
   output logic [WIDTH-1:0] duty_actual,
   output logic             pwm_out,
   output logic             pwm_n,
   output logic             period_start
);

   localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
   localparam logic [WIDTH-1:0] CNT_LAST  = '1;
   localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

   // Catch impossible configurations at elaboration time.
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("dpwm_gen_10b: PRESCALE must be >= 1");
   end
   if (DEADTIME < 0) begin : g_bad_deadtime
      $error("dpwm_gen_10b: DEADTIME must be >= 0");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [PW-1:0]    presc;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] shadow;
   logic             tick;
   logic             wrap;
   logic             drive;
   logic             raw_p0;

   assign tick   = (presc == PRESC_LAST);
   assign wrap   = tick && (cnt == CNT_LAST);
   // Outputs follow the compare only while running and still enabled; the
   // clock on which enable drops already forces both outputs low.
   assign drive  = (state == RUN) && enable;
   assign raw_p0 = (cnt < shadow);

   assign duty_actual = shadow;

   // Control FSM: prescaler, period counter, shadow duty and period_start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         presc        <= '0;
         cnt          <= '0;
         shadow       <= '0;
         period_start <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               presc        <= '0;
               cnt          <= '0;
               shadow       <= cant_corriente;
               period_start <= enable;
               if (enable) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!enable) begin
                  state        <= IDLE;
                  presc        <= '0;
                  cnt          <= '0;
                  period_start <= 1'b0;
               end else begin
                  period_start <= wrap;
                  if (tick) begin
                     presc <= '0;
                     cnt   <= cnt + CNT_ONE;
                  end else begin
                     presc <= presc + PRESC_ONE;
                  end
                  if (wrap) begin
                     shadow <= cant_corriente;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DPWM_DEADTIME_EN
   localparam int              DT_W    = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
   localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
   localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);
   localparam logic [DT_W-1:0] DT_ZERO = '0;

   logic [DT_W-1:0] dt_hi;
   logic [DT_W-1:0] dt_lo;
   logic [DT_W:0]   step_hi;
   logic [DT_W:0]   step_lo;

   // Next {output, counter} of one dead-time channel. A zero counter with the
   // output low means no delay is in progress; a rising target loads DEADTIME
   // and the output turns on once the count has expired. Any low target drops
   // the output and cancels a pending delay, which suppresses short pulses.
   function automatic logic [DT_W:0] dt_step(input logic            target,
                                             input logic            out_q,
                                             input logic [DT_W-1:0] ctr_q);
      logic [DT_W:0] nxt;
      nxt = {out_q, ctr_q};
      if (!target) begin
         nxt = '0;
      end else if (!out_q) begin
         if (DEADTIME == 0) begin
            nxt = {1'b1, DT_ZERO};
         end else if (ctr_q == DT_ZERO) begin
            nxt = {1'b0, DT_LOAD};
         end else if (ctr_q == DT_ONE) begin
            nxt = {1'b1, DT_ZERO};
         end else begin
            nxt = {1'b0, ctr_q - DT_ONE};
         end
      end
      return nxt;
   endfunction

   assign step_hi = dt_step(drive & raw_p0, pwm_out, dt_hi);
   assign step_lo = dt_step(drive & ~raw_p0, pwm_n, dt_lo);

   // Output stage with rising-edge dead time on both channels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_out <= 1'b0;
         pwm_n   <= 1'b0;
         dt_hi   <= '0;
         dt_lo   <= '0;
      end else begin
         {pwm_out, dt_hi} <= step_hi;
         {pwm_n, dt_lo}   <= step_lo;
      end
   end
`else
   // Output stage: registered compare result and its complement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_out <= 1'b0;
         pwm_n   <= 1'b0;
      end else if (drive) begin
         pwm_out <= raw_p0;
         pwm_n   <= ~raw_p0;
      end else begin
         pwm_out <= 1'b0;
         pwm_n   <= 1'b0;
      end
   end
`endif

endmodule
